// File: rtl/fp_accum_seq.sv
// rtl/fp_accum_seq.sv - binary32 accumulation sequencer around an external add/sub unit (optional FP_ACC_SUB_EN)
// The adder is purely combinational outside this block; its operands come only from registers.
module fp_accum_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_exc,
  input  logic             out_ready,
  output logic             busy,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_sub_signal,
  input  logic [31:0]      add_res,
  input  logic             add_exc
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      b_q, b_d;
  logic             sub_q, sub_d;
  logic             exc_q, exc_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sub_in;
  logic             last;

`ifdef FP_ACC_SUB_EN
  assign sub_in = in_sub;
`else
  logic unused_in_sub;
  assign unused_in_sub = in_sub;
  assign sub_in        = 1'b0;
`endif

  assign last = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      exc_q   <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      exc_q   <= exc_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    sub_d   = sub_q;
    exc_d   = exc_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = len;
          acc_d   = '0;
          exc_d   = 1'b0;
          first_d = 1'b1;
          state_d = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (first_q) begin
            // First sample seeds the accumulator directly; a subtract just flips its sign.
            acc_d   = {in_data[31] ^ sub_in, in_data[30:0]};
            first_d = 1'b0;
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = last ? S_DONE : S_LOAD;
          end else begin
            b_d     = in_data;
            sub_d   = sub_in;
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        acc_d   = add_res;
        exc_d   = exc_q | add_exc;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = last ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready       = (state_q == S_LOAD);
  assign out_valid      = (state_q == S_DONE);
  assign out_data       = out_valid ? acc_q : 32'h0;
  assign out_exc        = out_valid & exc_q;
  assign busy           = (state_q != S_IDLE);
  assign add_a          = acc_q;
  assign add_b          = b_q;
  assign add_sub_signal = sub_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// tb/tb_fp_accum_seq.sv - directed bench for fp_accum_seq with a stand-in adder and a real-valued sum model
// Honours FP_ACC_SUB_EN the same way the design does.
module tb_fp_accum_seq;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_sub = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_exc;
  logic             out_ready = 1'b1;
  logic             busy;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_sub_signal;
  logic [31:0]      add_res;
  logic             add_exc;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] smp[$];
  logic        sb[$];
  logic [31:0] exp_data = '0;
  logic        exp_exc = 1'b0;
  real         add_r;

  fp_accum_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_sub(in_sub), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_exc(out_exc), .out_ready(out_ready),
    .busy(busy), .add_a(add_a), .add_b(add_b), .add_sub_signal(add_sub_signal),
    .add_res(add_res), .add_exc(add_exc)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'h0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic        s;
    real         m;
    int          e;
    logic [22:0] fr;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    if (e > 127) return {s, 8'hFF, 23'h0};
    fr = 23'(longint'((m - 1.0) * 8388608.0));
    return {s, 8'(e + 127), fr};
  endfunction

  function automatic logic is_inf(input logic [31:0] b);
    return b[30:23] == 8'hFF;
  endfunction

  // Stand-in adder: raises add_exc on an Inf/NaN b operand or on overflow, so a later finite add stays clean.
  always_comb begin
    add_r   = 0.0;
    add_res = 32'h0;
    add_exc = 1'b0;
    if (is_inf(add_a) || is_inf(add_b)) begin
      add_res = 32'h7F800000;
      add_exc = is_inf(add_b);
    end else begin
      add_r   = f2r(add_a) + (add_sub_signal ? -f2r(add_b) : f2r(add_b));
      add_res = r2f(add_r);
      add_exc = is_inf(add_res);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        chk("model_out_data", out_data, exp_data);
        chk("model_out_exc", {31'h0, out_exc}, {31'h0, exp_exc});
      end
      chk("busy_cover", {31'h0, busy}, {31'h0, busy | out_valid | in_ready});
`ifndef FP_ACC_SUB_EN
      chk("sub_const0", {31'h0, add_sub_signal}, 32'h0);
`endif
    end
  end

  task automatic model(input int n);
    real  sum;
    logic inf;
    logic neg;
    sum = 0.0;
    inf = 1'b0;
    exp_exc = 1'b0;
    for (int i = 0; i < n; i++) begin
`ifdef FP_ACC_SUB_EN
      neg = sb[i];
`else
      neg = 1'b0;
`endif
      if (is_inf(smp[i])) begin
        inf = 1'b1;
        if (i > 0) exp_exc = 1'b1;
      end else begin
        sum = neg ? sum - f2r(smp[i]) : sum + f2r(smp[i]);
      end
    end
    exp_data = (n == 0) ? 32'h0 : (inf ? 32'h7F800000 : r2f(sum));
  endtask

  task automatic run_job(input int n, input logic [31:0] lit, input logic lit_exc, input int hold);
    int   edges;
    int   idx;
    logic hs;
    logic ir_seen;
    model(n);
    out_ready = (hold == 0);
    @(negedge clk);
    start = 1'b1;
    len = CNT_W'(n);
    idx = 0;
    ir_seen = 1'b0;
    in_valid = (n > 0);
    if (n > 0) begin in_data = smp[0]; in_sub = sb[0]; end
    @(posedge clk);
    #1 start = 1'b0;
    edges = 1;
    forever begin
      @(negedge clk);
      if (out_valid || edges > 4 * n + 8) break;
      hs = in_ready & in_valid;
      ir_seen |= in_ready;
      @(posedge clk);
      #1 edges++;
      if (hs) begin
        idx++;
        if (idx < n) begin in_data = smp[idx]; in_sub = sb[idx]; end
        else in_valid = 1'b0;
      end
    end
    chk("latency", edges, (n == 0) ? 1 : 2 * n);
    chk("out_valid", {31'h0, out_valid}, 32'h1);
    chk("out_data", out_data, lit);
    chk("out_exc", {31'h0, out_exc}, {31'h0, lit_exc});
    if (n == 0) chk("no_in_ready", {31'h0, ir_seen}, 32'h0);
    for (int k = 0; k < hold; k++) begin
      start = k[0];
      len = 8'd5;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_data", out_data, lit);
      chk("hold_exc", {31'h0, out_exc}, {31'h0, lit_exc});
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drop", {31'h0, out_valid}, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_misc", {28'h0, out_exc, busy, add_sub_signal, 1'b0}, 32'h0);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);
    reset = 1'b0;

    smp = '{32'h3F800000, 32'h40000000, 32'h40400000}; sb = '{0, 0, 0};
    run_job(3, 32'h40C00000, 1'b0, 0);

    smp = {}; sb = {};
    run_job(0, 32'h00000000, 1'b0, 0);

    smp = '{32'h40A00000, 32'h7F800000}; sb = '{0, 0};
    run_job(2, 32'h7F800000, 1'b1, 0);

    smp = '{32'h3F800000}; sb = '{0};
    run_job(1, 32'h3F800000, 1'b0, 0);

    smp = '{32'h3F800000, 32'h7F800000, 32'h3F800000}; sb = '{0, 0, 0};
    run_job(3, 32'h7F800000, 1'b1, 0);

    smp = '{32'h40400000, 32'h40800000}; sb = '{0, 0};
    run_job(2, 32'h40E00000, 1'b0, 10);

    smp = '{32'h40A00000, 32'h40000000}; sb = '{0, 1};
`ifdef FP_ACC_SUB_EN
    run_job(2, 32'h40400000, 1'b0, 0);
`else
    run_job(2, 32'h40E00000, 1'b0, 0);
`endif

    smp = {}; sb = {};
    for (int i = 0; i < 255; i++) begin smp.push_back(32'h3F800000); sb.push_back(1'b0); end
    run_job(255, 32'h437F0000, 1'b0, 0);

    @(negedge clk);
    start = 1'b1;
    len = 8'd4;
    in_valid = 1'b1;
    in_data = 32'h3F800000;
    in_sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_add_state", {30'h0, busy, in_ready}, 32'h2);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_out", {29'h0, in_ready, out_valid, out_exc}, 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_add", add_a | add_b, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    smp = '{32'h41200000}; sb = '{0};
    run_job(1, 32'h41200000, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
